// File: rtl/axi_lite_ram.sv
// AXI4-Lite subordinate wrapping a word-organised RAM.
// AW and W are captured independently into one-entry holding registers. The
// RAM write ("fire") happens once both are held and the B slot is free. Reads
// are single-cycle from the RAM into a registered R channel.
//
// Handshake rule on every channel: a transfer occurs on the rising edge where
// valid and ready are both 1. A source holds valid and its payload stable until
// that edge. The ready outputs here depend only on internal state. All
// valid/data outputs come straight from flops.
module axi_lite_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic [31:0]      mem [DEPTH];

  logic             aw_full;
  logic [IDX_W-1:0] aw_idx;
  logic             w_full;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             bvalid_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;

  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             fire;
  logic [IDX_W-1:0] ar_idx;

  // Protection bits, byte offset and bits above the decoded window carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{axi_awprot, axi_arprot,
                         axi_awaddr[31:ADDR_WIDTH], axi_awaddr[1:0],
                         axi_araddr[31:ADDR_WIDTH], axi_araddr[1:0]};

  // Readys come from state only; the write commits when both halves are held and B is free.
  always_comb begin
    axi_awready = !aw_full;
    axi_wready  = !w_full;
    axi_arready = !rvalid_q;
    aw_hs       = axi_awvalid && !aw_full;
    w_hs        = axi_wvalid && !w_full;
    ar_hs       = axi_arvalid && !rvalid_q;
    fire        = aw_full && w_full && (!bvalid_q || axi_bready);
    ar_idx      = axi_araddr[ADDR_WIDTH-1:2];
  end

  // Write address holding register: filled on handshake, emptied by fire.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
    end else if (aw_hs) begin
      aw_full <= 1'b1;
      aw_idx  <= axi_awaddr[ADDR_WIDTH-1:2];
    end else if (fire) begin
      aw_full <= 1'b0;
    end
  end

  // Write data holding register: filled on handshake, emptied by fire.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      w_full <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (w_hs) begin
      w_full <= 1'b1;
      w_data <= axi_wdata;
      w_strb <= axi_wstrb;
    end else if (fire) begin
      w_full <= 1'b0;
    end
  end

  // Write response: a fire on the same edge as an accepted B keeps bvalid high.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bvalid_q <= 1'b0;
    end else if (fire) begin
      bvalid_q <= 1'b1;
    end else if (axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // RAM byte-lane update on fire; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (fire) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel: the RAM is sampled before this edge's write lands, so reads see the old word.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= mem[ar_idx];
    end else if (axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Output mapping; both responses are always OKAY.
  always_comb begin
    axi_bvalid = bvalid_q;
    axi_bresp  = 2'b00;
    axi_rvalid = rvalid_q;
    axi_rdata  = rdata_q;
    axi_rresp  = 2'b00;
  end

endmodule
